// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port dmem between the processor (always wins)
//               and one secondary requester served in processor-idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 64,
   parameter int CNT_W        = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              proc_en,
   input  logic              proc_wren,
   input  logic [ADDR_W-1:0] proc_addr,
   input  logic [DATA_W-1:0] proc_wdata,
   output logic [DATA_W-1:0] proc_q,
   input  logic              sec_req,
   input  logic              sec_we,
   input  logic [ADDR_W-1:0] sec_addr,
   input  logic [DATA_W-1:0] sec_wdata,
   output logic              sec_ack,
   output logic [DATA_W-1:0] sec_rdata,
   output logic              sec_starved,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PEND = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_limit   = CNT_W'(STARVE_LIMIT);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_rdata;
   logic              r_starved;

   logic              w_busy;
   logic              w_grant;
   logic              w_pend;
   logic [ADDR_W-1:0] w_sec_addr;
   logic              w_sec_we;
   logic [DATA_W-1:0] w_sec_wdata;
   logic [CNT_W-1:0]  w_cnt_inc;

   always_comb begin
      w_busy      = proc_en | proc_wren;
      w_pend      = (r_state == S_PEND);
      // Reset gates the grant so a dropped request never reaches dmem.
      w_grant     = ~reset & ~w_busy & (((r_state == S_IDLE) & sec_req) | w_pend);
      w_sec_addr  = w_pend ? r_addr  : sec_addr;
      w_sec_we    = w_pend ? r_we    : sec_we;
      w_sec_wdata = w_pend ? r_wdata : sec_wdata;
      w_cnt_inc   = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;
      mem_addr    = w_grant ? w_sec_addr  : proc_addr;
      mem_data    = w_grant ? w_sec_wdata : proc_wdata;
      mem_wren    = w_grant ? w_sec_we    : proc_wren;
      proc_q      = mem_q;
      sec_ack     = (r_state == S_ACK);
      sec_rdata   = r_rdata;
      sec_starved = r_starved;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_cnt     <= '0;
         r_rdata   <= '0;
         r_starved <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (sec_req) begin
                  if (w_busy) begin
                     r_state   <= S_PEND;
                     r_addr    <= sec_addr;
                     r_we      <= sec_we;
                     r_wdata   <= sec_wdata;
                     r_cnt     <= c_cnt_one;
                     r_starved <= (c_cnt_one >= c_limit);
                  end else begin
                     r_state <= S_ACK;
                     if (!sec_we) r_rdata <= mem_q;
                  end
               end
            end
            S_PEND: begin
               if (w_busy) begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc >= c_limit) r_starved <= 1'b1;
               end else begin
                  r_state   <= S_ACK;
                  r_cnt     <= '0;
                  r_starved <= 1'b0;
                  if (!r_we) r_rdata <= mem_q;
               end
            end
            S_ACK:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Vector-table and directed-sequence bench for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          proc_en, proc_wren;
   logic [AW-1:0] proc_addr;
   logic [DW-1:0] proc_wdata;
   logic [DW-1:0] proc_q;
   logic          sec_req, sec_we;
   logic [AW-1:0] sec_addr;
   logic [DW-1:0] sec_wdata;
   logic          sec_ack;
   logic [DW-1:0] sec_rdata;
   logic          sec_starved;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_wren;
   logic [DW-1:0] mem_q;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .CNT_W(8)) dut (
      .clock(clk), .reset(reset),
      .proc_en(proc_en), .proc_wren(proc_wren), .proc_addr(proc_addr),
      .proc_wdata(proc_wdata), .proc_q(proc_q),
      .sec_req(sec_req), .sec_we(sec_we), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
      .sec_ack(sec_ack), .sec_rdata(sec_rdata), .sec_starved(sec_starved),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
   );

   // dmem model: syncram clocked on the falling edge, registered q.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(negedge clk) begin
      if (mem_wren) mem[mem_addr] <= mem_data;
      mem_q <= mem[mem_addr];
   end

   typedef struct {
      logic          pe, pw;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      logic          sr, sw;
      logic [AW-1:0] sa;
      logic [DW-1:0] sd;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          ew, eack;
      logic [DW-1:0] erd;
      logic          est;
   } vec_t;

   vec_t vt [11];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic pe, input logic pw, input logic [AW-1:0] pa,
                         input logic [DW-1:0] pd, input logic sr, input logic sw,
                         input logic [AW-1:0] sa, input logic [DW-1:0] sd);
      proc_en = pe; proc_wren = pw; proc_addr = pa; proc_wdata = pd;
      sec_req = sr; sec_we = sw; sec_addr = sa; sec_wdata = sd;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
      mem[12'h010] = 32'hDEADBEEF;
   end

   initial begin
      //        pe    pw    pa       pd            sr    sw    sa       sd
      //        ea       ed            ew    eack  erd           est
      vt[0]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 12'h010, 32'h0,
                 12'h010, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
      vt[1]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,
                 12'h000, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b1, 1'b0, 12'h100, 32'h0,        1'b1, 1'b1, 12'h020, 32'h1234,
                 12'h100, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
      vt[3]  = vt[2];
      vt[4]  = '{1'b1, 1'b1, 12'h101, 32'hAAAA,     1'b1, 1'b1, 12'h020, 32'h1234,
                 12'h101, 32'hAAAA,     1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
      vt[5]  = vt[2];
      vt[6]  = vt[2];
      vt[6].est = 1'b1;
      vt[7]  = '{1'b0, 1'b0, 12'h100, 32'h0,        1'b1, 1'b1, 12'h020, 32'h1234,
                 12'h020, 32'h1234,     1'b1, 1'b0, 32'hDEADBEEF, 1'b1};
      vt[8]  = vt[1];
      vt[9]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 12'h020, 32'h0,
                 12'h020, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
      vt[10] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,
                 12'h000, 32'h0,        1'b0, 1'b1, 32'h1234,     1'b0};

      // Reset with a processor store and a sec write both asserted.
      reset = 1'b1;
      set_in(1'b0, 1'b1, 12'h3FF, 32'h55, 1'b1, 1'b1, 12'h111, 32'h99);
      next_cyc(); #2;
      chk("rst_mem_addr", 32'(mem_addr), 32'h3FF);
      chk("rst_mem_wren", 32'(mem_wren), 32'h1);
      chk("rst_mem_data", mem_data, 32'h55);
      chk("rst_ack",      32'(sec_ack), 32'h0);
      chk("rst_rdata",    sec_rdata, 32'h0);
      chk("rst_starved",  32'(sec_starved), 32'h0);
      next_cyc();
      set_in(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'h111, 32'h99);
      #2;
      chk("rst_no_sec_wren", 32'(mem_wren), 32'h0);
      chk("rst_proc_addr",   32'(mem_addr), 32'h000);

      // Table: idle read, pending write with starvation, read-back.
      next_cyc();
      reset = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (i > 0) next_cyc();
         set_in(vt[i].pe, vt[i].pw, vt[i].pa, vt[i].pd, vt[i].sr, vt[i].sw, vt[i].sa, vt[i].sd);
         #2;
         chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].ea));
         chk($sformatf("v%0d_mem_data", i), mem_data, vt[i].ed);
         chk($sformatf("v%0d_mem_wren", i), 32'(mem_wren), 32'(vt[i].ew));
         chk($sformatf("v%0d_ack", i), 32'(sec_ack), 32'(vt[i].eack));
         chk($sformatf("v%0d_rdata", i), sec_rdata, vt[i].erd);
         chk($sformatf("v%0d_starved", i), 32'(sec_starved), 32'(vt[i].est));
         chk($sformatf("v%0d_proc_q", i), proc_q, mem_q);
      end

      // Same-address collision: processor store wins, sec write lands next.
      next_cyc();
      set_in(1'b1, 1'b1, 12'h030, 32'h7, 1'b1, 1'b1, 12'h030, 32'h9);
      #2;
      chk("col_a_data", mem_data, 32'h7);
      chk("col_a_wren", 32'(mem_wren), 32'h1);
      next_cyc();
      set_in(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'h030, 32'h9);
      #2;
      chk("col_b_addr", 32'(mem_addr), 32'h030);
      chk("col_b_data", mem_data, 32'h9);
      chk("col_b_ack",  32'(sec_ack), 32'h0);
      next_cyc();
      set_in(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
      #2;
      chk("col_c_ack", 32'(sec_ack), 32'h1);
      chk("col_mem",   mem[12'h030], 32'h9);
      next_cyc(); #2;
      chk("col_d_ack", 32'(sec_ack), 32'h0);

      // Reset while pending drops the request.
      next_cyc();
      set_in(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'h040, 32'h77);
      #2;
      chk("rp_a_wren", 32'(mem_wren), 32'h0);
      next_cyc();
      reset = 1'b1;
      set_in(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'h040, 32'h77);
      #2;
      chk("rp_b_wren", 32'(mem_wren), 32'h0);
      chk("rp_b_addr", 32'(mem_addr), 32'h000);
      next_cyc();
      reset = 1'b0;
      set_in(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
      #2;
      chk("rp_c_ack",   32'(sec_ack), 32'h0);
      chk("rp_c_rdata", sec_rdata, 32'h0);
      chk("rp_c_wren",  32'(mem_wren), 32'h0);
      chk("rp_c_mem",   mem[12'h040], 32'h0);
      next_cyc();
      set_in(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'h040, 32'h77);
      #2;
      chk("rp_d_addr", 32'(mem_addr), 32'h040);
      chk("rp_d_wren", 32'(mem_wren), 32'h1);
      next_cyc();
      set_in(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
      #2;
      chk("rp_e_ack", 32'(sec_ack), 32'h1);
      chk("rp_e_mem", mem[12'h040], 32'h77);

      // Request held across ACK: two acks, one access each, gap of one cycle.
      for (int c = 0; c < 4; c++) begin
         next_cyc();
         set_in(1'b0, 1'b0, 12'h200, 32'h0, 1'b1, 1'b1, 12'h050, 32'hCAFE);
         #2;
         chk($sformatf("hold%0d_ack", c),  32'(sec_ack),  32'(c % 2));
         chk($sformatf("hold%0d_wren", c), 32'(mem_wren), 32'((c + 1) % 2));
         chk($sformatf("hold%0d_addr", c), 32'(mem_addr), (c % 2 == 0) ? 32'h050 : 32'h200);
      end
      next_cyc();
      set_in(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
      #2;
      chk("hold_mem", mem[12'h050], 32'hCAFE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
